fetch_stage: RTL and testbench

- Instruction-fetch stage of the LEGv8 pipeline. Sits directly upstream of the 64-word instruction ROM and downstream of the branch-resolution logic.
- Owns the program counter and drives the ROM word address (6 bits).
- Registers the returned 32-bit instruction with its PC into the IF/ID pipeline register.
- Supports stall, branch redirect and flush.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_flopr_en.sv | 22 ++
 rtl/fetch_stage.sv | 110 +++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the LEGv8 instruction-fetch stage.
// HALT_INSTR and fetch_state_t are only used when FETCH_HALT_DETECT_EN is defined.
package fetch_pkg;

  localparam int          PC_STEP    = 4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  // CBZ XZR to itself: the end-of-program idiom.
  localparam logic [31:0] HALT_INSTR = 32'hb400_001f;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/pc_flopr_en.sv
// Parameterised register with enable and asynchronous active-high reset to zero.
// Holds the program counter for the fetch stage.
module pc_flopr_en #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Load d on enabled rising edges; reset clears the register at any time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage of the LEGv8 pipeline. It owns the PC, drives the
// combinational ROM word address and registers {pc, instr, valid} into IF/ID.
// Supports stall, branch redirect (which also flushes IF/ID) and wrap-around
// ROM addressing.
// Optional halt detection is built when FETCH_HALT_DETECT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int N  = 64,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_target,
  output logic [AW-1:0] imem_addr,
  input  logic [31:0]   imem_q,
  output logic [N-1:0]  if_id_pc,
  output logic [31:0]   if_id_instr,
  output logic          if_id_valid,
  output logic [N-1:0]  pc_out,
  output logic          halted
);

  logic [N-1:0] pc_q;
  logic [N-1:0] pc_d;
  logic         pc_en;
  logic         in_halt;

  // A redirect beats a stall, because the stall belongs to the squashed
  // younger instruction. While halted, the PC is frozen.
  always_comb begin
    pc_d  = pc_q + N'(PC_STEP);
    pc_en = 1'b0;
    if (!in_halt) begin
      if (redirect) begin
        pc_d  = {redirect_target[N-1:2], 2'b00};
        pc_en = 1'b1;
      end else if (!stall) begin
        pc_en = 1'b1;
      end
    end
  end

  pc_flopr_en #(.W(N)) u_pc (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_d),
    .q     (pc_q)
  );

  // PCs at or beyond the ROM size alias onto the ROM by dropping the upper bits.
  assign imem_addr = pc_q[AW+1:2];
  assign pc_out    = pc_q;

  // IF/ID register: insert a bubble on halt or redirect, hold on stall,
  // otherwise capture the word fetched this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (in_halt || redirect) begin
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc_q;
      if_id_instr <= imem_q;
      if_id_valid <= 1'b1;
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  fetch_state_t state_q;
  fetch_state_t state_d;

  // Halt state register; only reset brings the stage back to RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt once the end-of-program idiom is actually registered into IF/ID.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && !stall && !redirect && imem_q == HALT_INSTR) begin
      state_d = HALT;
    end
  end

  // The halt flag is decoded directly from the registered state.
  always_comb begin
    in_halt = 1'b0;
    if (state_q == HALT) begin
      in_halt = 1'b1;
    end
  end
`else
  assign in_halt = 1'b0;
`endif

  assign halted = in_halt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The ROM model returns addr+1 for each
// word; in halt mode, word 3 is replaced by the CBZ-to-self halt idiom.
// The halt checks follow FETCH_HALT_DETECT_EN.
module tb_fetch_stage;

  localparam int N  = 64;
  localparam int AW = 6;
  localparam logic [31:0] HALT_WORD = 32'hb400_001f;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          redirect;
  logic [N-1:0]  redirect_target;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_q;
  logic [N-1:0]  if_id_pc;
  logic [31:0]   if_id_instr;
  logic          if_id_valid;
  logic [N-1:0]  pc_out;
  logic          halted;
  logic          halt_rom;

  int num_checks;
  int num_fail;

  fetch_stage #(.N(N), .AW(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_addr       (imem_addr),
    .imem_q          (imem_q),
    .if_id_pc        (if_id_pc),
    .if_id_instr     (if_id_instr),
    .if_id_valid     (if_id_valid),
    .pc_out          (pc_out),
    .halted          (halted)
  );

  // Free-running clock with rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational ROM model.
  always_comb begin
    imem_q = 32'(imem_addr) + 32'd1;
    if (halt_rom && imem_addr == 6'd3) begin
      imem_q = HALT_WORD;
    end
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    assert (obs === exp) else begin
      num_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_ifid(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                            input logic valid);
    check_output({tag, "_pc"}, if_id_pc, pc);
    check_output({tag, "_instr"}, 64'(if_id_instr), 64'(instr));
    check_output({tag, "_valid"}, 64'(if_id_valid), 64'(valid));
  endtask

  // Advance one rising edge, then settle on the falling edge for sampling.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    num_checks      = 0;
    num_fail        = 0;
    reset           = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirect_target = '0;
    halt_rom        = 1'b0;

    $display("[TB] reset state");
    step();
    check_output("rst_pc", pc_out, 64'h0);
    check_output("rst_addr", 64'(imem_addr), 64'h0);
    check_ifid("rst_ifid", 64'h0, 32'h0, 1'b0);
    check_output("rst_halted", 64'(halted), 64'h0);
    reset = 1'b0;

    $display("[TB] free-running fetch");
    step();
    check_ifid("run0", 64'h0, 32'd1, 1'b1);
    check_output("run0_addr", 64'(imem_addr), 64'd1);
    step();
    check_ifid("run1", 64'h4, 32'd2, 1'b1);
    step();
    check_ifid("run2", 64'h8, 32'd3, 1'b1);
    check_output("run2_addr", 64'(imem_addr), 64'd3);
    step();
    check_ifid("run3", 64'hc, 32'd4, 1'b1);
    check_output("run3_pc", pc_out, 64'h10);
    check_output("run3_addr", 64'(imem_addr), 64'd4);

    $display("[TB] stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("stall_addr", 64'(imem_addr), 64'd4);
      check_output("stall_pc", pc_out, 64'h10);
      check_ifid("stall_ifid", 64'hc, 32'd4, 1'b1);
    end
    stall = 1'b0;
    step();
    check_ifid("unstall", 64'h10, 32'd5, 1'b1);
    check_output("unstall_pc", pc_out, 64'h14);

    $display("[TB] redirect with stall");
    stall           = 1'b1;
    redirect        = 1'b1;
    redirect_target = 64'h2b;
    step();
    check_output("redir_pc", pc_out, 64'h28);
    check_output("redir_addr", 64'(imem_addr), 64'd10);
    check_ifid("redir_flush", 64'h0, 32'h0, 1'b0);
    stall    = 1'b0;
    redirect = 1'b0;
    step();
    check_ifid("redir_next", 64'h28, 32'd11, 1'b1);
    check_output("redir_next_pc", pc_out, 64'h2c);

    $display("[TB] consecutive redirects");
    redirect        = 1'b1;
    redirect_target = 64'h100;
    step();
    check_output("redir2a_pc", pc_out, 64'h100);
    check_ifid("redir2a", 64'h0, 32'h0, 1'b0);
    redirect_target = 64'h7;
    step();
    check_output("redir2b_pc", pc_out, 64'h4);
    check_ifid("redir2b", 64'h0, 32'h0, 1'b0);
    redirect = 1'b0;
    step();
    check_ifid("redir2c", 64'h4, 32'd2, 1'b1);

    $display("[TB] address wrap");
    apply_reset();
    for (int i = 0; i < 63; i++) begin
      step();
    end
    check_output("wrap_pre_pc", pc_out, 64'hfc);
    check_output("wrap_pre_addr", 64'(imem_addr), 64'd63);
    step();
    check_output("wrap_pc", pc_out, 64'h100);
    check_output("wrap_addr", 64'(imem_addr), 64'd0);
    check_ifid("wrap_ifid", 64'hfc, 32'd64, 1'b1);
    step();
    check_ifid("wrap_next", 64'h100, 32'd1, 1'b1);

    $display("[TB] async reset during redirect");
    redirect        = 1'b1;
    redirect_target = 64'h80;
    #2;
    reset = 1'b1;
    #1;
    check_output("arst_pc", pc_out, 64'h0);
    check_output("arst_ifid_pc", if_id_pc, 64'h0);
    check_output("arst_valid", 64'(if_id_valid), 64'h0);
    @(negedge clk);
    check_output("arst_hold_pc", pc_out, 64'h0);
    reset    = 1'b0;
    redirect = 1'b0;
    step();
    check_ifid("arst_after", 64'h0, 32'd1, 1'b1);
    check_output("arst_after_pc", pc_out, 64'h4);

    $display("[TB] halt instruction");
    halt_rom = 1'b1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      step();
    end
    check_ifid("halt_ifid", 64'hc, HALT_WORD, 1'b1);
    check_output("halt_pc", pc_out, 64'h10);
`ifdef FETCH_HALT_DETECT_EN
    check_output("halt_flag", 64'(halted), 64'h1);
    step();
    check_ifid("halt_bubble", 64'h0, 32'h0, 1'b0);
    check_output("halt_frozen_pc", pc_out, 64'h10);
    redirect        = 1'b1;
    redirect_target = 64'h40;
    step();
    redirect = 1'b0;
    check_output("halt_redir_pc", pc_out, 64'h10);
    check_ifid("halt_redir_ifid", 64'h0, 32'h0, 1'b0);
    step();
    check_output("halt_still", 64'(halted), 64'h1);
    apply_reset();
    check_output("halt_cleared", 64'(halted), 64'h0);
`else
    check_output("nohalt_flag", 64'(halted), 64'h0);
    step();
    check_ifid("nohalt_next", 64'h10, 32'd5, 1'b1);
    check_output("nohalt_pc", pc_out, 64'h14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
